// File: rtl/fifo_pkg.sv
// Shared constants and coverage-state encoding for the FIFO pointer/status controller.
package fifo_pkg;

  localparam int A_DEFAULT        = 4;
  localparam int AF_LEVEL_DEFAULT = 14;
  localparam int DEPTH            = 2 ** A_DEFAULT;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } cov_state_t;

  function automatic cov_state_t cov_state(input logic is_empty, input logic is_full);
    if (is_empty) return EMPTY;
    if (is_full)  return FULL;
    return PARTIAL;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a register-bank FIFO (sync write, async read).
// Optional sticky overflow/underflow outputs are enabled with FIFO_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int A        = A_DEFAULT,
  parameter int AF_LEVEL = AF_LEVEL_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  output logic         wr_en,
  output logic [A-1:0] address_w,
  output logic [A-1:0] address_r,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic         overflow,
  output logic         underflow,
`endif
  output logic [A:0]   count
);

  localparam logic [A:0] DEPTH_C = (A+1)'(2 ** A);
  localparam logic [A:0] AF_C    = (A+1)'(AF_LEVEL);

  logic       push_ok;
  logic       pop_ok;
  logic [A:0] count_nxt;

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  always_comb begin
    push_ok   = push & (~full | pop);
    pop_ok    = pop & ~empty;
    wr_en     = push_ok & reset_n;
    count_nxt = count + (A+1)'(push_ok) - (A+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address_w   <= '0;
      address_r   <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) address_w <= address_w + 1'b1;
      if (pop_ok)  address_r <= address_r + 1'b1;
      count       <= count_nxt;
      // Flags follow the next count so they change in the same cycle as count.
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AF_C);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow  <= 1'b1;
      if (pop & empty)        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural storage bank.
// Sticky error flags are checked when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_ctrl;

  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         push;
  logic         pop;
  logic         wr_en;
  logic [A-1:0] address_w;
  logic [A-1:0] address_r;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic [A:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic         overflow;
  logic         underflow;
`endif

  logic [7:0] din;
  logic [7:0] mem [16];
  logic [7:0] dout;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_ctrl #(.A(A), .AF_LEVEL(14)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .pop         (pop),
    .wr_en       (wr_en),
    .address_w   (address_w),
    .address_r   (address_r),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[address_w] <= din;
  assign dout = mem[address_r];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive requests mid-cycle; caller checks combinational outputs before calling tick.
  task automatic drive(input logic rn, input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    reset_n = rn;
    push    = p;
    pop     = q;
    din     = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = 8'h00;

    // Reset then idle
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);
    chk("rst_af",    32'(almost_full), 0);
    chk("rst_aw",    32'(address_w), 0);
    chk("rst_ar",    32'(address_r), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
`endif

    // Sixteen pushes fill the FIFO
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(i));
      chk("fill_wr_en", 32'(wr_en), 1);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af",    32'(almost_full), (i + 1 >= 14) ? 1 : 0);
      chk("fill_full",  32'(full), (i == 15) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
    end
    chk("fill_aw_wrap", 32'(address_w), 0);

    // Push on full is ignored
    drive(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("ovf_wr_en", 32'(wr_en), 0);
    tick();
    chk("ovf_count", 32'(count), 16);
    chk("ovf_aw",    32'(address_w), 0);
    chk("ovf_full",  32'(full), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_no_unf", 32'(underflow), 0);
`endif

    // Full with push+pop: write lands in the slot being read
    drive(1'b1, 1'b1, 1'b1, 8'hAA);
    chk("fpp_wr_en", 32'(wr_en), 1);
    chk("fpp_dout",  32'(dout), 8'h00);
    tick();
    chk("fpp_count", 32'(count), 16);
    chk("fpp_full",  32'(full), 1);
    chk("fpp_aw",    32'(address_w), 1);
    chk("fpp_ar",    32'(address_r), 1);

    // Drain: 0x01..0x0F then 0xAA
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(dout), (i == 16) ? 32'hAA : 32'(i));
      tick();
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_full",  32'(full), 0);
    chk("drain_af",    32'(almost_full), 0);
    chk("drain_ar",    32'(address_r), 1);

    // Empty with push+pop: only the push is accepted
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    chk("epp_wr_en", 32'(wr_en), 1);
    tick();
    chk("epp_count", 32'(count), 1);
    chk("epp_ar",    32'(address_r), 1);
    chk("epp_aw",    32'(address_w), 2);
    chk("epp_empty", 32'(empty), 0);

    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("epp_dout", 32'(dout), 8'h55);
    tick();
    chk("pop1_count", 32'(count), 0);
    chk("pop1_empty", 32'(empty), 1);

    // Lone pop on empty changes nothing
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    chk("unf_count", 32'(count), 0);
    chk("unf_ar",    32'(address_r), 2);
    chk("unf_aw",    32'(address_w), 2);
    chk("unf_empty", 32'(empty), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_flag", 32'(underflow), 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("unf_sticky", 32'(underflow), 1);
    chk("ovf_sticky", 32'(overflow), 1);
`endif

    // Fill to 5, then reset together with push
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
      tick();
    end
    chk("five_count", 32'(count), 5);
    chk("five_aw",    32'(address_w), 7);
    drive(1'b0, 1'b1, 1'b0, 8'h99);
    chk("rstpush_wr_en", 32'(wr_en), 0);
    tick();
    chk("rstpush_count", 32'(count), 0);
    chk("rstpush_aw",    32'(address_w), 0);
    chk("rstpush_ar",    32'(address_r), 0);
    chk("rstpush_empty", 32'(empty), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rstpush_ovf", 32'(overflow), 0);
    chk("rstpush_unf", 32'(underflow), 0);
`endif

    // Idle after reset holds state
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("idle_count", 32'(count), 0);
    chk("idle_aw",    32'(address_w), 0);
    chk("idle_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
